// File: rtl/dual_src_pipe_merge.sv
// Two valid/ready sources merged round-robin into a DEPTH-stage elastic pipeline.
// Each delivered word carries a tag naming the source it came from.
module dual_src_pipe_merge #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in2_data,
    input  logic             in2_valid,
    output logic             in2_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       occupancy
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_src;
    logic             r_lastGrant2;
    logic [4:0]       r_occupancy;

    logic [DEPTH-1:0] w_stageReady;
    logic             w_grant2;
    logic             w_accept;
    logic             w_outFire;
    logic [WIDTH-1:0] w_acceptData;

    // A stage can load when it is empty or everything downstream of it can move.
    always_comb begin : readyChain
        logic w_chain;
        w_stageReady = '0;
        w_chain      = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_chain         = w_chain || !r_valid[i];
            w_stageReady[i] = w_chain;
        end
    end

    always_comb begin
        w_grant2     = in2_valid && (!in1_valid || !r_lastGrant2);
        in1_ready    = !reset && w_stageReady[0] && !w_grant2;
        in2_ready    = !reset && w_stageReady[0] && w_grant2;
        w_accept     = (in1_valid && in1_ready) || (in2_valid && in2_ready);
        w_acceptData = w_grant2 ? in2_data : in1_data;
        w_outFire    = r_valid[DEPTH-1] && out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= '0;
            r_src        <= '0;
            r_lastGrant2 <= 1'b1;
            r_occupancy  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                if (w_stageReady[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                        r_src[i]  <= r_src[i-1];
                    end
                end
            end
            if (w_stageReady[0]) begin
                r_valid[0] <= w_accept;
                if (w_accept) begin
                    r_data[0] <= w_acceptData;
                    r_src[0]  <= w_grant2;
                end
            end
            if (w_accept) begin
                r_lastGrant2 <= w_grant2;
            end
            case ({w_accept, w_outFire})
                2'b10:   r_occupancy <= r_occupancy + 5'd1;
                2'b01:   r_occupancy <= r_occupancy - 5'd1;
                default: r_occupancy <= r_occupancy;
            endcase
        end
    end

    assign out_data  = r_data[DEPTH-1];
    assign out_src   = r_src[DEPTH-1];
    assign out_valid = r_valid[DEPTH-1];
    assign occupancy = r_occupancy;

endmodule

// File: tb/tb_dual_src_pipe_merge.sv
// Scoreboard bench for dual_src_pipe_merge: a DEPTH=4 and a DEPTH=1 instance.
// Accepted words are queued with their accept cycle and popped when they leave.
module tb_dual_src_pipe_merge;

    typedef struct {
        logic       src;
        logic [7:0] data;
        int         cyc;
    } item_t;

    logic       clk;
    logic       reset;
    logic [7:0] in1Data4, in2Data4, outData4, in1Data1, in2Data1, outData1;
    logic       in1Valid4, in2Valid4, in1Ready4, in2Ready4, outSrc4, outValid4, outReady4;
    logic       in1Valid1, in2Valid1, in1Ready1, in2Ready1, outSrc1, outValid1, outReady1;
    logic [4:0] occ4, occ1;

    item_t q4[$];
    item_t q1[$];
    bit    lastSrc4, lastSrc1;
    int    cycNum;
    int    nCompared;
    int    nMismatched;

    bit         obsAcc1, obsAcc2, obsFire, obsSrc, obsBothReady, obsModelSrc, obsReady1;
    logic [7:0] obsData;
    logic [4:0] obsOcc;
    int         obsExpOcc;

    dual_src_pipe_merge #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset),
        .in1_data(in1Data4), .in1_valid(in1Valid4), .in1_ready(in1Ready4),
        .in2_data(in2Data4), .in2_valid(in2Valid4), .in2_ready(in2Ready4),
        .out_data(outData4), .out_src(outSrc4), .out_valid(outValid4),
        .out_ready(outReady4), .occupancy(occ4)
    );

    dual_src_pipe_merge #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clk(clk), .reset(reset),
        .in1_data(in1Data1), .in1_valid(in1Valid1), .in1_ready(in1Ready1),
        .in2_data(in2Data1), .in2_valid(in2Valid1), .in2_ready(in2Ready1),
        .out_data(outData1), .out_src(outSrc1), .out_valid(outValid1),
        .out_ready(outReady1), .occupancy(occ1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One cycle: drive at the falling edge, sample 1 time unit later, queue any accepted word.
    task automatic drive_cycle(input bit sel1, input bit rst, input bit v1, input logic [7:0] d1,
                               input bit v2, input logic [7:0] d2, input bit ordy);
        item_t it;
        @(negedge clk);
        cycNum++;
        reset = rst;
        if (sel1) begin
            in1Valid1 = v1; in1Data1 = d1; in2Valid1 = v2; in2Data1 = d2; outReady1 = ordy;
            in1Valid4 = 1'b0; in2Valid4 = 1'b0; outReady4 = 1'b0;
        end else begin
            in1Valid4 = v1; in1Data4 = d1; in2Valid4 = v2; in2Data4 = d2; outReady4 = ordy;
            in1Valid1 = 1'b0; in2Valid1 = 1'b0; outReady1 = 1'b0;
        end
        #1;
        if (sel1) begin
            obsAcc1 = in1Valid1 && in1Ready1;   obsAcc2 = in2Valid1 && in2Ready1;
            obsFire = outValid1 && outReady1;   obsData = outData1; obsSrc = outSrc1;
            obsOcc  = occ1;  obsExpOcc = q1.size();
            obsBothReady = in1Ready1 && in2Ready1; obsReady1 = in1Ready1;
            obsModelSrc  = !lastSrc1;
        end else begin
            obsAcc1 = in1Valid4 && in1Ready4;   obsAcc2 = in2Valid4 && in2Ready4;
            obsFire = outValid4 && outReady4;   obsData = outData4; obsSrc = outSrc4;
            obsOcc  = occ4;  obsExpOcc = q4.size();
            obsBothReady = in1Ready4 && in2Ready4; obsReady1 = in1Ready4;
            obsModelSrc  = !lastSrc4;
        end
        it.src  = obsAcc2;
        it.data = obsAcc2 ? d2 : d1;
        it.cyc  = cycNum;
        if (obsAcc1 || obsAcc2) begin
            if (sel1) begin q1.push_back(it); lastSrc1 = obsAcc2; end
            else      begin q4.push_back(it); lastSrc4 = obsAcc2; end
        end
        if (rst) begin
            q4.delete(); q1.delete();
            lastSrc4 = 1'b1; lastSrc1 = 1'b1;
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive_cycle(1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 8'h88, 1'b0);
            nCompared++;
            if ({in1Ready4, in2Ready4, in1Ready1, in2Ready1} !== 4'b0000) begin
                nMismatched++;
                $display("[TB] FAIL reset_ready: got %b, expected 0000",
                         {in1Ready4, in2Ready4, in1Ready1, in2Ready1});
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        nCompared++;
        if ({outValid4, outSrc4, outData4, occ4} !== 15'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_out4: got valid=%b src=%b data=%h occ=%0d, expected all 0",
                     outValid4, outSrc4, outData4, occ4);
        end
        nCompared++;
        if ({outValid1, outSrc1, outData1, occ1} !== 15'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_out1: got valid=%b src=%b data=%h occ=%0d, expected all 0",
                     outValid1, outSrc1, outData1, occ1);
        end
    endtask

    task automatic test_in1_stream();
        logic [7:0] words [4];
        item_t      expItem;
        int k = 0, firstAcc = -1, firstOut = -1, lastOut = -1, peak = 0, nOut = 0;
        words = '{8'h11, 8'h22, 8'h33, 8'h00};
        for (int c = 0; c < 30 && (k < 3 || q4.size() > 0); c++) begin
            drive_cycle(1'b0, 1'b0, k < 3, words[k], 1'b0, 8'h00, 1'b1);
            if (int'(obsOcc) > peak) peak = int'(obsOcc);
            if (obsAcc1) begin
                if (firstAcc < 0) firstAcc = cycNum;
                k++;
            end
            if (obsFire) begin
                nCompared++;
                if (q4.size() == 0) begin
                    nMismatched++;
                    $display("[TB] FAIL stream_out: got src=%0d data=%h, expected no output", obsSrc, obsData);
                end else begin
                    expItem = q4.pop_front();
                    if ({obsSrc, obsData} !== {1'b0, expItem.data} || cycNum - expItem.cyc != 4) begin
                        nMismatched++;
                        $display("[TB] FAIL stream_out: got src=%0d data=%h lat=%0d, expected src=0 data=%h lat=4",
                                 obsSrc, obsData, cycNum - expItem.cyc, expItem.data);
                    end
                end
                if (firstOut < 0) firstOut = cycNum;
                lastOut = cycNum;
                nOut++;
            end
        end
        nCompared++;
        if (k != 3 || nOut != 3) begin
            nMismatched++;
            $display("[TB] FAIL stream_count: got accepts=%0d outputs=%0d, expected 3/3", k, nOut);
        end
        nCompared++;
        if (firstOut - firstAcc != 4 || lastOut - firstOut != 2) begin
            nMismatched++;
            $display("[TB] FAIL stream_timing: got first latency=%0d span=%0d, expected 4/2",
                     firstOut - firstAcc, lastOut - firstOut);
        end
        nCompared++;
        if (peak != 3) begin
            nMismatched++;
            $display("[TB] FAIL stream_peak_occ: got %0d, expected 3", peak);
        end
    endtask

    task automatic test_contention();
        logic [7:0] n1 = 8'h00, n2 = 8'h00, expD;
        item_t      expItem;
        int nAcc = 0, nOut = 0, firstAcc = -1, lastAcc = -1;
        bit stim;
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 40 && (nAcc < 8 || q4.size() > 0); c++) begin
            stim = nAcc < 8;
            drive_cycle(1'b0, 1'b0, stim, 8'hA0 + n1, stim, 8'hB0 + n2, 1'b1);
            nCompared++;
            if (obsBothReady) begin
                nMismatched++;
                $display("[TB] FAIL contention_excl: got both readies high, expected at most one");
            end
            if (obsAcc1 || obsAcc2) begin
                nCompared++;
                if (obsAcc2 !== (nAcc % 2 == 1)) begin
                    nMismatched++;
                    $display("[TB] FAIL contention_grant: accept %0d got src=%0d, expected %0d",
                             nAcc, obsAcc2, nAcc % 2);
                end
                if (firstAcc < 0) firstAcc = cycNum;
                lastAcc = cycNum;
                if (obsAcc1) n1++; else n2++;
                nAcc++;
            end
            if (obsFire) begin
                expD = (nOut % 2 == 0) ? 8'hA0 + 8'(nOut / 2) : 8'hB0 + 8'(nOut / 2);
                nCompared++;
                if ({obsSrc, obsData} !== {1'(nOut % 2), expD}) begin
                    nMismatched++;
                    $display("[TB] FAIL contention_out: got src=%0d data=%h, expected src=%0d data=%h",
                             obsSrc, obsData, nOut % 2, expD);
                end
                if (q4.size() > 0) expItem = q4.pop_front();
                nOut++;
            end
        end
        nCompared++;
        if (nOut != 8 || lastAcc - firstAcc != 7) begin
            nMismatched++;
            $display("[TB] FAIL contention_rate: got outputs=%0d accept span=%0d, expected 8/7",
                     nOut, lastAcc - firstAcc);
        end
    endtask

    task automatic test_stall_full();
        logic [7:0] nextW = 8'h01;
        item_t      expItem;
        int nAcc = 0;
        for (int c = 0; c < 8; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, nextW, 1'b0, 8'h00, 1'b0);
            if (obsAcc1) begin nAcc++; nextW++; end
        end
        nCompared++;
        if (nAcc != 4 || obsOcc !== 5'd4 || obsReady1 !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL stall_fill: got accepts=%0d occ=%0d in1_ready=%b, expected 4/4/0",
                     nAcc, obsOcc, obsReady1);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, nextW, 1'b0, 8'h00, 1'b1);
        nCompared++;
        if (!obsFire || obsData !== 8'h01 || !obsAcc1) begin
            nMismatched++;
            $display("[TB] FAIL stall_release: got fire=%b data=%h accept=%b, expected 1/01/1",
                     obsFire, obsData, obsAcc1);
        end
        if (obsFire && q4.size() > 0) expItem = q4.pop_front();
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        nCompared++;
        if (obsOcc !== 5'd4) begin
            nMismatched++;
            $display("[TB] FAIL stall_occ: got %0d, expected 4", obsOcc);
        end
        nextW = 8'h02;
        for (int c = 0; c < 20 && q4.size() > 0; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            if (obsFire) begin
                expItem = q4.pop_front();
                nCompared++;
                if (obsData !== nextW || obsSrc !== 1'b0) begin
                    nMismatched++;
                    $display("[TB] FAIL stall_drain: got src=%0d data=%h, expected src=0 data=%h",
                             obsSrc, obsData, nextW);
                end
                nextW++;
            end
        end
        nCompared++;
        if (nextW !== 8'h06) begin
            nMismatched++;
            $display("[TB] FAIL stall_drain_count: got next word %h, expected 06", nextW);
        end
    endtask

    task automatic test_random();
        logic [7:0] c1 = 8'h00, c2 = 8'h00;
        item_t      expItem;
        int nAcc = 0, nOut = 0;
        bit v1, v2, ordy, stim;
        for (int c = 0; c < 20000 && (nAcc < 1000 || q4.size() > 0); c++) begin
            stim = nAcc < 1000;
            v1   = stim && ($urandom_range(0, 9) < 7);
            v2   = stim && ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 1) == 1);
            drive_cycle(1'b0, 1'b0, v1, c1, v2, c2, ordy);
            nCompared++;
            if (obsOcc !== 5'(obsExpOcc) || obsBothReady) begin
                nMismatched++;
                $display("[TB] FAIL random_occ: got occ=%0d bothReady=%b, expected occ=%0d bothReady=0",
                         obsOcc, obsBothReady, obsExpOcc);
            end
            if (v1 && v2 && (obsAcc1 || obsAcc2)) begin
                nCompared++;
                if (obsAcc2 !== obsModelSrc) begin
                    nMismatched++;
                    $display("[TB] FAIL random_rr: got src=%0d, expected %0d", obsAcc2, obsModelSrc);
                end
            end
            if (obsAcc1) begin c1++; nAcc++; end
            if (obsAcc2) begin c2++; nAcc++; end
            if (obsFire) begin
                nCompared++;
                if (q4.size() == 0) begin
                    nMismatched++;
                    $display("[TB] FAIL random_out: got src=%0d data=%h, expected no output", obsSrc, obsData);
                end else begin
                    expItem = q4.pop_front();
                    if ({obsSrc, obsData} !== {expItem.src, expItem.data}) begin
                        nMismatched++;
                        $display("[TB] FAIL random_out: got src=%0d data=%h, expected src=%0d data=%h",
                                 obsSrc, obsData, expItem.src, expItem.data);
                    end
                end
                nOut++;
            end
        end
        nCompared++;
        if (nAcc < 1000 || nOut != nAcc || q4.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL random_count: got accepts=%0d outputs=%0d left=%0d, expected equal and none left",
                     nAcc, nOut, q4.size());
        end
    endtask

    task automatic test_reset_midflight();
        item_t expItem;
        int nAcc = 0, nOut = 0;
        for (int c = 0; c < 10 && nAcc < 3; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 8'hC0 + 8'(nAcc), 1'b0, 8'h00, 1'b0);
            if (obsAcc1) nAcc++;
        end
        drive_cycle(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1, 8'hEF, 1'b0);
        nCompared++;
        if (obsAcc1 || obsAcc2) begin
            nMismatched++;
            $display("[TB] FAIL midreset_accept: got accept during reset, expected none");
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        nCompared++;
        if ({outValid4, outData4, obsOcc} !== 14'd0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_state: got valid=%b data=%h occ=%0d, expected 0/00/0",
                     outValid4, outData4, obsOcc);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h6B, 1'b1);
        nCompared++;
        if ({obsAcc1, obsAcc2} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL midreset_grant: got acc1=%b acc2=%b, expected in1 granted", obsAcc1, obsAcc2);
        end
        for (int c = 0; c < 20 && q4.size() > 0; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            if (obsFire) begin
                expItem = q4.pop_front();
                nCompared++;
                if ({obsSrc, obsData} !== 9'h05A) begin
                    nMismatched++;
                    $display("[TB] FAIL midreset_out: got src=%0d data=%h, expected src=0 data=5a",
                             obsSrc, obsData);
                end
                nOut++;
            end
        end
        nCompared++;
        if (nOut != 1) begin
            nMismatched++;
            $display("[TB] FAIL midreset_count: got %0d outputs, expected 1", nOut);
        end
    endtask

    task automatic test_depth1();
        logic [7:0] n1 = 8'h00, n2 = 8'h00;
        item_t      expItem;
        int nAcc = 0, nOut = 0, firstAcc = -1, lastAcc = -1;
        bit stim;
        for (int c = 0; c < 30 && (nAcc < 8 || q1.size() > 0); c++) begin
            stim = nAcc < 8;
            drive_cycle(1'b1, 1'b0, stim, 8'h30 + n1, stim, 8'h40 + n2, 1'b1);
            nCompared++;
            if (obsBothReady) begin
                nMismatched++;
                $display("[TB] FAIL depth1_excl: got both readies high, expected at most one");
            end
            if (obsAcc1 || obsAcc2) begin
                nCompared++;
                if (obsAcc2 !== (nAcc % 2 == 1)) begin
                    nMismatched++;
                    $display("[TB] FAIL depth1_grant: accept %0d got src=%0d, expected %0d",
                             nAcc, obsAcc2, nAcc % 2);
                end
                if (firstAcc < 0) firstAcc = cycNum;
                lastAcc = cycNum;
                if (obsAcc1) n1++; else n2++;
                nAcc++;
            end
            if (obsFire) begin
                nCompared++;
                if (q1.size() == 0) begin
                    nMismatched++;
                    $display("[TB] FAIL depth1_out: got src=%0d data=%h, expected no output", obsSrc, obsData);
                end else begin
                    expItem = q1.pop_front();
                    if ({obsSrc, obsData} !== {expItem.src, expItem.data} || cycNum - expItem.cyc != 1) begin
                        nMismatched++;
                        $display("[TB] FAIL depth1_out: got src=%0d data=%h lat=%0d, expected src=%0d data=%h lat=1",
                                 obsSrc, obsData, cycNum - expItem.cyc, expItem.src, expItem.data);
                    end
                end
                nOut++;
            end
        end
        nCompared++;
        if (nOut != 8 || lastAcc - firstAcc != 7) begin
            nMismatched++;
            $display("[TB] FAIL depth1_rate: got outputs=%0d accept span=%0d, expected 8/7",
                     nOut, lastAcc - firstAcc);
        end
    endtask

    initial begin
        reset = 1'b1;
        in1Valid4 = 1'b0; in2Valid4 = 1'b0; outReady4 = 1'b0; in1Data4 = '0; in2Data4 = '0;
        in1Valid1 = 1'b0; in2Valid1 = 1'b0; outReady1 = 1'b0; in1Data1 = '0; in2Data1 = '0;
        lastSrc4 = 1'b1; lastSrc1 = 1'b1;
        cycNum = 0; nCompared = 0; nMismatched = 0;

        $display("[TB] starting dual_src_pipe_merge bench");
        test_reset();
        test_in1_stream();
        test_contention();
        test_stall_full();
        test_random();
        test_reset_midflight();
        test_depth1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/dual_src_pipe_merge.md
Name: dual_src_pipe_merge

Overview:
- Merges two valid/ready sources into one DEPTH-stage registered pipeline with round-robin arbitration.
- Drives a single valid/ready sink, tagging each item with its originating source.
- Serves as the registered, protocol-correct counterpart to fan-in buffer chains where two paths converge on one net. Instead of two drivers on one net, each word is arbitrated, staged and delivered exactly once.

Parameters:
- WIDTH, 8, data width of each source and of the output.
- DEPTH, 4, number of register stages between arbitration and output; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in1_data  input  WIDTH  source 1 payload.
- in1_valid  input  1  source 1 has a word.
- in1_ready  output  1  source 1 word accepted this cycle when in1_valid && in1_ready.
- in2_data  input  WIDTH  source 2 payload.
- in2_valid  input  1  source 2 has a word.
- in2_ready  output  1  source 2 word accepted this cycle when in2_valid && in2_ready.
- out_data  output  WIDTH  payload at the last stage.
- out_src  output  1  0 = word came from in1, 1 = from in2.
- out_valid  output  1  last stage holds a word.
- out_ready  input  1  sink accepts; transfer when out_valid && out_ready.
- occupancy  output  5  number of valid stages, 0..DEPTH.

Behaviour:

Pipeline
- Stages S[0..DEPTH-1]; each stage holds valid, data and src.
- stage_ready[DEPTH-1] = !valid[DEPTH-1] || out_ready.
- stage_ready[i] = !valid[i] || stage_ready[i+1].
- On a clock edge where stage_ready[i+1] is true, S[i] moves to S[i+1]. A stage that moves out and receives nothing becomes invalid.
- A stage whose successor is not ready holds data and src unchanged. Data must never be overwritten while valid and stalled.
- out_data, out_src and out_valid are driven directly from S[DEPTH-1] (registered, with no combinational path from inputs).

Arbitration
- Arbitration is combinational on in1_valid, in2_valid, stage_ready[0] and the rr pointer.
- Only one valid source: that source is granted.
- Both sources valid: grant goes to the source not granted most recently (rr pointer).
- inX_ready = grant_X && stage_ready[0]. At most one of in1_ready and in2_ready is high in any cycle.
- An in*_ready may depend combinationally on the other source's valid.
- rr pointer updates only on an actual acceptance; it records the accepted source.
- Accepted word is written into S[0] with src = accepted source index.

Latency and throughput
- With no stall, a word accepted at edge N is presented on out_* after edge N+DEPTH-1, i.e. DEPTH cycles of latency from acceptance to out_valid.
- Sustained throughput is 1 word/cycle.
- Under contention with both sources continuously valid, grants alternate 1,2,1,2,...

occupancy
- Registered count of valid stages.
- Increments on accept without output transfer; decrements on output transfer without accept; unchanged when both or neither occur.
- Never exceeds DEPTH and never goes below 0.

Stall and full conditions
- With out_ready low, the pipeline fills. Once all stages are valid, stage_ready[0] = 0 and both in*_ready = 0.
- The cycle out_ready rises with the pipeline full, one word leaves and, in the same cycle, one new word may be accepted (ready ripples combinationally). occupancy stays at DEPTH.

Reset
- When reset is high at an edge: all stage valids = 0, data/src = 0, rr pointer = "last granted in2" (so in1 wins first contention), occupancy = 0.
- Resulting outputs: out_valid = 0, out_data = 0, out_src = 0.
- While reset is high, in1_ready and in2_ready are forced to 0 and no word is accepted.
- Reset mid-operation discards all in-flight words; no partial transfer follows.

Test Plan:
1. DEPTH=4, in1 only, words 0x11,0x22,0x33 on consecutive cycles, out_ready=1 → out_data 0x11,0x22,0x33 with out_src=0, first out_valid 4 cycles after first accept, consecutive cycles, occupancy peaks 3.
2. Both sources valid continuously (in1=0xA0.., in2=0xB0.., incrementing), out_ready=1 → out_src sequence 0,1,0,1; out_data 0xA0,0xB0,0xA1,0xB1; in1_ready and in2_ready never high together.
3. out_ready=0, in1 streaming 0x01.. → exactly 4 accepts (0x01–0x04), occupancy=4, in1_ready=0 thereafter. Raise out_ready for 1 cycle → 0x01 delivered, 0x05 accepted the same cycle, occupancy stays 4.
4. Random out_ready toggling, both sources random valid, 1000 words → scoreboard per source: each word appears exactly once and in per-source order; no word is lost or duplicated.
5. Pipeline holding 3 words, assert reset for 1 cycle → next cycle out_valid=0, occupancy=0, out_data=0. First contention after reset grants in1.
6. DEPTH=1 build, both valid, out_ready=1 → 1-cycle latency, alternating grants, 1 word/cycle sustained.
